// File: rtl/mips_dvc_arb_pkg.sv
// Shared types and constants for the mips_dvc two-master device-bus arbiter.
//   - arb_state_e : arbiter FSM encoding
//   - MEM_CTL_IDLE: device access code meaning "no access"
//   - LOCK_MAX    : longest run of locked grants before the lock is ignored once
//   - req_valid() : a request counts only with a nonzero access code
package mips_dvc_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    localparam logic [3:0] MEM_CTL_IDLE = 4'b0000;

    localparam int unsigned LOCK_MAX = 4;

    function automatic logic req_valid(input logic req, input logic [3:0] mem_ctl);
        return req && (mem_ctl != MEM_CTL_IDLE);
    endfunction

endpackage

// File: rtl/mips_arb_rr2.sv
// Combinational 2-way round-robin picker.
//   req_i       : qualified requests, one bit per master
//   last_i      : index of the master granted most recently
//   lock_hint_i : keep the grant with last_i when it is still requesting
//   win_valid_o : at least one request is pending
//   win_id_o    : index of the winning master (0 when nothing is pending)
module mips_arb_rr2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    input  logic       lock_hint_i,
    output logic       win_valid_o,
    output logic       win_id_o
);

    always_comb begin
        win_valid_o = |req_i;
        win_id_o    = 1'b0;
        if (lock_hint_i && req_i[last_i]) begin
            win_id_o = last_i;
        end else if (&req_i) begin
            win_id_o = ~last_i;
        end else begin
            win_id_o = req_i[1];
        end
    end

endmodule

// File: rtl/mips_dvc_arb.sv
// Two-master arbiter in front of the mips_dvc device bus.
// Accesses are serialised with round-robin priority: the winner's address, data and access
// code are driven onto the device bus, the code for exactly one cycle, then after RD_LAT
// cycles the device read data is returned with a one-cycle done pulse to the winner.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   mX_req_i                request, held until mX_done_o
//   mX_addr_i/din_i         access address / write data
//   mX_mem_ctl_i            access code, nonzero means an access
//   mX_lock_i               (DVC_ARB_LOCK_EN only) keep the bus for the next access
//   mX_dout_o, mX_done_o    read data and completion pulse
//   dev_addr_o/din_o        device address / write data, held through the access
//   dev_mem_ctl_o           device access code, nonzero only in the issue cycle
//   dev_dout_i              device read data
//   gnt_id_o                master owning the bus (trace)
//   busy_o                  arbiter not idle
//
// Build option: define DVC_ARB_LOCK_EN to add the lock inputs for atomic sequences.
module mips_dvc_arb
    import mips_dvc_arb_pkg::*;
#(
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned AW     = 32,
    parameter int unsigned DW     = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,

    input  logic          m0_req_i,
    input  logic [AW-1:0] m0_addr_i,
    input  logic [DW-1:0] m0_din_i,
    input  logic [3:0]    m0_mem_ctl_i,
    input  logic          m1_req_i,
    input  logic [AW-1:0] m1_addr_i,
    input  logic [DW-1:0] m1_din_i,
    input  logic [3:0]    m1_mem_ctl_i,
`ifdef DVC_ARB_LOCK_EN
    input  logic          m0_lock_i,
    input  logic          m1_lock_i,
`endif
    output logic [DW-1:0] m0_dout_o,
    output logic          m0_done_o,
    output logic [DW-1:0] m1_dout_o,
    output logic          m1_done_o,

    output logic [AW-1:0] dev_addr_o,
    output logic [DW-1:0] dev_din_o,
    output logic [3:0]    dev_mem_ctl_o,
    input  logic [DW-1:0] dev_dout_i,

    output logic          gnt_id_o,
    output logic          busy_o
);

    if (RD_LAT < 1 || RD_LAT > 15) begin : g_bad_rd_lat
        $error("mips_dvc_arb: RD_LAT must be in 1..15");
    end

    localparam logic [3:0] CntLoad = 4'(RD_LAT - 1);

    arb_state_e    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          last_q, last_d;
    logic          gnt_q, gnt_d;
    logic          busy_q, busy_d;
    logic [AW-1:0] dev_addr_q, dev_addr_d;
    logic [DW-1:0] dev_din_q, dev_din_d;
    logic [3:0]    dev_ctl_q, dev_ctl_d;
    logic [DW-1:0] m0_dout_q, m0_dout_d, m1_dout_q, m1_dout_d;
    logic          m0_done_q, m0_done_d, m1_done_q, m1_done_d;

    logic [1:0]    req_vld;
    logic          lock_hint;
    logic          win_valid;
    logic          win_id;

    assign req_vld = {req_valid(m1_req_i, m1_mem_ctl_i), req_valid(m0_req_i, m0_mem_ctl_i)};

`ifdef DVC_ARB_LOCK_EN
    localparam logic [2:0] StreakMax = 3'(LOCK_MAX);

    // lock_pend_q: the last winner asked to keep the bus.
    // streak_q: consecutive grants to last_q, saturating at StreakMax.
    logic       lock_pend_q, lock_pend_d;
    logic [2:0] streak_q, streak_d;

    // A lock that has already won StreakMax grants in a row loses its priority once.
    assign lock_hint = lock_pend_q && (streak_q < StreakMax);
`else
    assign lock_hint = 1'b0;
`endif

    mips_arb_rr2 u_rr2 (
        .req_i       (req_vld),
        .last_i      (last_q),
        .lock_hint_i (lock_hint),
        .win_valid_o (win_valid),
        .win_id_o    (win_id)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        gnt_d      = gnt_q;
        dev_addr_d = dev_addr_q;
        dev_din_d  = dev_din_q;
        dev_ctl_d  = dev_ctl_q;
        m0_dout_d  = m0_dout_q;
        m1_dout_d  = m1_dout_q;
        m0_done_d  = 1'b0;
        m1_done_d  = 1'b0;
`ifdef DVC_ARB_LOCK_EN
        lock_pend_d = lock_pend_q;
        streak_d    = streak_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (win_valid) begin
                    dev_addr_d = win_id ? m1_addr_i    : m0_addr_i;
                    dev_din_d  = win_id ? m1_din_i     : m0_din_i;
                    dev_ctl_d  = win_id ? m1_mem_ctl_i : m0_mem_ctl_i;
                    gnt_d      = win_id;
                    last_d     = win_id;
                    state_d    = ISSUE;
`ifdef DVC_ARB_LOCK_EN
                    lock_pend_d = 1'b0;
                    if (win_id != last_q) begin
                        streak_d = 3'd1;
                    end else if (streak_q != StreakMax) begin
                        streak_d = streak_q + 3'd1;
                    end
`endif
                end
            end
            ISSUE: begin
                // The code was presented during this cycle only.
                dev_ctl_d = MEM_CTL_IDLE;
                cnt_d     = CntLoad;
                state_d   = WAIT;
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    if (gnt_q) begin
                        m1_dout_d = dev_dout_i;
                        m1_done_d = 1'b1;
                    end else begin
                        m0_dout_d = dev_dout_i;
                        m0_done_d = 1'b1;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
`ifdef DVC_ARB_LOCK_EN
                lock_pend_d = gnt_q ? m1_lock_i : m0_lock_i;
`endif
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            last_q     <= 1'b1;
            gnt_q      <= 1'b0;
            busy_q     <= 1'b0;
            dev_addr_q <= '0;
            dev_din_q  <= '0;
            dev_ctl_q  <= MEM_CTL_IDLE;
            m0_dout_q  <= '0;
            m1_dout_q  <= '0;
            m0_done_q  <= 1'b0;
            m1_done_q  <= 1'b0;
`ifdef DVC_ARB_LOCK_EN
            lock_pend_q <= 1'b0;
            streak_q    <= 3'd0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            gnt_q      <= gnt_d;
            busy_q     <= busy_d;
            dev_addr_q <= dev_addr_d;
            dev_din_q  <= dev_din_d;
            dev_ctl_q  <= dev_ctl_d;
            m0_dout_q  <= m0_dout_d;
            m1_dout_q  <= m1_dout_d;
            m0_done_q  <= m0_done_d;
            m1_done_q  <= m1_done_d;
`ifdef DVC_ARB_LOCK_EN
            lock_pend_q <= lock_pend_d;
            streak_q    <= streak_d;
`endif
        end
    end

    assign m0_dout_o     = m0_dout_q;
    assign m0_done_o     = m0_done_q;
    assign m1_dout_o     = m1_dout_q;
    assign m1_done_o     = m1_done_q;
    assign dev_addr_o    = dev_addr_q;
    assign dev_din_o     = dev_din_q;
    assign dev_mem_ctl_o = dev_ctl_q;
    assign gnt_id_o      = gnt_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_mips_dvc_arb.sv
// Directed bench for mips_dvc_arb. Two instances share the master/device stimulus:
// u_lat1 with RD_LAT = 1 and u_lat4 with RD_LAT = 4. Each test starts from a reset so
// both instances are in step. Define DVC_ARB_LOCK_EN to also run the lock scenario.
module tb_mips_dvc_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic [31:0] m0_addr = '0, m0_din = '0, m1_addr = '0, m1_din = '0, dev_dout = '0;
    logic [3:0]  m0_ctl = '0, m1_ctl = '0;
`ifdef DVC_ARB_LOCK_EN
    logic        m0_lock = 1'b0, m1_lock = 1'b0;
`endif

    logic [31:0] a_m0_dout, a_m1_dout, a_dev_addr, a_dev_din;
    logic        a_m0_done, a_m1_done, a_gnt, a_busy;
    logic [3:0]  a_dev_ctl;
    logic [31:0] b_m0_dout, b_m1_dout, b_dev_addr, b_dev_din;
    logic        b_m0_done, b_m1_done, b_gnt, b_busy;
    logic [3:0]  b_dev_ctl;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mips_dvc_arb #(.RD_LAT(1), .AW(32), .DW(32)) u_lat1 (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_din_i(m0_din), .m0_mem_ctl_i(m0_ctl),
        .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_din_i(m1_din), .m1_mem_ctl_i(m1_ctl),
`ifdef DVC_ARB_LOCK_EN
        .m0_lock_i(m0_lock), .m1_lock_i(m1_lock),
`endif
        .m0_dout_o(a_m0_dout), .m0_done_o(a_m0_done),
        .m1_dout_o(a_m1_dout), .m1_done_o(a_m1_done),
        .dev_addr_o(a_dev_addr), .dev_din_o(a_dev_din), .dev_mem_ctl_o(a_dev_ctl),
        .dev_dout_i(dev_dout), .gnt_id_o(a_gnt), .busy_o(a_busy)
    );

    mips_dvc_arb #(.RD_LAT(4), .AW(32), .DW(32)) u_lat4 (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_din_i(m0_din), .m0_mem_ctl_i(m0_ctl),
        .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_din_i(m1_din), .m1_mem_ctl_i(m1_ctl),
`ifdef DVC_ARB_LOCK_EN
        .m0_lock_i(m0_lock), .m1_lock_i(m1_lock),
`endif
        .m0_dout_o(b_m0_dout), .m0_done_o(b_m0_done),
        .m1_dout_o(b_m1_dout), .m1_done_o(b_m1_done),
        .dev_addr_o(b_dev_addr), .dev_din_o(b_dev_din), .dev_mem_ctl_o(b_dev_ctl),
        .dev_dout_i(dev_dout), .gnt_id_o(b_gnt), .busy_o(b_busy)
    );

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m0_req = 1'b0; m1_req = 1'b0; m0_ctl = '0; m1_ctl = '0;
        m0_addr = '0; m1_addr = '0; m0_din = '0; m1_din = '0; dev_dout = '0;
`ifdef DVC_ARB_LOCK_EN
        m0_lock = 1'b0; m1_lock = 1'b0;
`endif
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({a_dev_ctl, a_busy, a_gnt, a_m0_done, a_m1_done} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_ctrl: got ctl=%h busy=%b gnt=%b d0=%b d1=%b, expected all 0",
                     a_dev_ctl, a_busy, a_gnt, a_m0_done, a_m1_done);
        end
        n_checks++;
        if ({a_dev_addr, a_dev_din, a_m0_dout, a_m1_dout} !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_data: got addr=%h din=%h dout0=%h dout1=%h, expected 0",
                     a_dev_addr, a_dev_din, a_m0_dout, a_m1_dout);
        end
    endtask

    // Single m0 read with RD_LAT = 1: issue at N+1, done at N+3.
    task automatic test_single_read();
        do_reset();
        m0_req = 1'b1; m0_addr = 32'h0000_0010; m0_ctl = 4'h1; dev_dout = 32'hDEAD_BEEF;
        step();
        n_checks++;
        if ({a_dev_ctl, a_dev_addr, a_gnt, a_busy} !== {4'h1, 32'h10, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL single_issue: got ctl=%h addr=%h gnt=%b busy=%b, expected 1 10 0 1",
                     a_dev_ctl, a_dev_addr, a_gnt, a_busy);
        end
        step();
        n_checks++;
        if ({a_dev_ctl, a_m0_done} !== 5'h00) begin
            n_fail++;
            $display("FAIL single_wait: got ctl=%h done0=%b, expected 0 0", a_dev_ctl, a_m0_done);
        end
        step();
        n_checks++;
        if ({a_m0_done, a_m1_done, a_m0_dout} !== {2'b10, 32'hDEAD_BEEF}) begin
            n_fail++;
            $display("FAIL single_done: got d0=%b d1=%b dout0=%h, expected 1 0 deadbeef",
                     a_m0_done, a_m1_done, a_m0_dout);
        end
        m0_req = 1'b0; m0_ctl = 4'h0;
        step();
        n_checks++;
        if ({a_m0_done, a_busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL single_after: got done0=%b busy=%b, expected 0 0", a_m0_done, a_busy);
        end
    endtask

    // Both masters requesting continuously: grants alternate 0,1,0,1.
    task automatic test_round_robin();
        logic        exp_id;
        logic [31:0] last0;
        do_reset();
        m0_req = 1'b1; m0_addr = 32'h100; m0_ctl = 4'h1;
        m1_req = 1'b1; m1_addr = 32'h200; m1_ctl = 4'h2;
        last0 = 32'h0;
        for (int i = 0; i < 4; i++) begin
            exp_id = i[0];
            for (int k = 0; k < 20; k++) begin
                if (a_dev_ctl != 4'h0) break;
                step();
            end
            n_checks++;
            if ({a_gnt, a_dev_ctl, a_dev_addr} !==
                {exp_id, (exp_id ? 4'h2 : 4'h1), (exp_id ? 32'h200 : 32'h100)}) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: got gnt=%b ctl=%h addr=%h, expected gnt=%b",
                         i, a_gnt, a_dev_ctl, a_dev_addr, exp_id);
            end
            dev_dout = 32'hA000_0000 + 32'(i);
            for (int k = 0; k < 20; k++) begin
                if (a_m0_done || a_m1_done) break;
                step();
            end
            n_checks++;
            if ({a_m1_done, a_m0_done} !== (exp_id ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL rr_done[%0d]: got d1=%b d0=%b, expected winner %b only",
                         i, a_m1_done, a_m0_done, exp_id);
            end
            n_checks++;
            if ((exp_id ? a_m1_dout : a_m0_dout) !== 32'hA000_0000 + 32'(i)) begin
                n_fail++;
                $display("FAIL rr_dout[%0d]: got %h, expected %h", i,
                         (exp_id ? a_m1_dout : a_m0_dout), 32'hA000_0000 + 32'(i));
            end
            if (!exp_id) last0 = 32'hA000_0000 + 32'(i);
            if (exp_id) begin
                n_checks++;
                if (a_m0_dout !== last0) begin
                    n_fail++;
                    $display("FAIL rr_loser_hold[%0d]: got %h, expected %h", i, a_m0_dout, last0);
                end
            end
            step();
        end
    endtask

    // m1 write with RD_LAT = 4: bus held from issue to done, done 6 cycles after sample.
    task automatic test_lat4_write();
        do_reset();
        m1_req = 1'b1; m1_addr = 32'h20; m1_din = 32'h1234_5678; m1_ctl = 4'h2;
        dev_dout = 32'hCAFE_F00D;
        step();
        n_checks++;
        if ({b_dev_ctl, b_dev_addr, b_dev_din, b_gnt} !== {4'h2, 32'h20, 32'h1234_5678, 1'b1}) begin
            n_fail++;
            $display("FAIL lat4_issue: got ctl=%h addr=%h din=%h gnt=%b, expected 2 20 12345678 1",
                     b_dev_ctl, b_dev_addr, b_dev_din, b_gnt);
        end
        for (int c = 2; c <= 5; c++) begin
            step();
            n_checks++;
            if ({b_dev_ctl, b_dev_addr, b_dev_din, b_m1_done} !==
                {4'h0, 32'h20, 32'h1234_5678, 1'b0}) begin
                n_fail++;
                $display("FAIL lat4_wait[N+%0d]: got ctl=%h addr=%h din=%h done1=%b", c,
                         b_dev_ctl, b_dev_addr, b_dev_din, b_m1_done);
            end
        end
        step();
        n_checks++;
        if ({b_m1_done, b_m0_done, b_m1_dout, b_dev_addr, b_dev_din} !==
            {2'b10, 32'hCAFE_F00D, 32'h20, 32'h1234_5678}) begin
            n_fail++;
            $display("FAIL lat4_done: got d1=%b d0=%b dout1=%h addr=%h din=%h",
                     b_m1_done, b_m0_done, b_m1_dout, b_dev_addr, b_dev_din);
        end
        m1_req = 1'b0; m1_ctl = 4'h0;
        step();
        n_checks++;
        if (b_m1_done !== 1'b0) begin
            n_fail++;
            $display("FAIL lat4_pulse: got done1=%b, expected 0", b_m1_done);
        end
    endtask

    // Reset during WAIT aborts the access; no done ever follows.
    task automatic test_reset_in_wait();
        logic seen;
        do_reset();
        m0_req = 1'b1; m0_addr = 32'h30; m0_ctl = 4'h1;
        step();
        step();
        rst = 1'b1; m0_req = 1'b0; m0_ctl = 4'h0;
        step();
        n_checks++;
        if ({b_busy, b_dev_ctl, b_dev_addr, b_m0_done} !== 38'h0) begin
            n_fail++;
            $display("FAIL rstwait_state: got busy=%b ctl=%h addr=%h done0=%b, expected 0",
                     b_busy, b_dev_ctl, b_dev_addr, b_m0_done);
        end
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            seen = seen | b_m0_done | b_m1_done | b_busy;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL rstwait_nodone: got done/busy activity=%b, expected 0", seen);
        end
    endtask

    // mem_ctl = 0 is never granted; dropping req mid-access still completes it.
    task automatic test_ctl_zero_and_drop();
        do_reset();
        m0_req = 1'b1; m0_addr = 32'h40; m0_ctl = 4'h0; dev_dout = 32'h5555_AAAA;
        for (int c = 0; c < 10; c++) begin
            step();
            n_checks++;
            if ({a_busy, a_dev_ctl} !== 5'h00) begin
                n_fail++;
                $display("FAIL ctl0_idle[%0d]: got busy=%b ctl=%h, expected 0 0", c, a_busy, a_dev_ctl);
            end
        end
        m0_ctl = 4'h3;
        step();
        n_checks++;
        if (a_dev_ctl !== 4'h3) begin
            n_fail++;
            $display("FAIL drop_issue: got ctl=%h, expected 3", a_dev_ctl);
        end
        step();
        m0_req = 1'b0; m0_ctl = 4'h0;
        step();
        n_checks++;
        if ({a_m0_done, a_m0_dout} !== {1'b1, 32'h5555_AAAA}) begin
            n_fail++;
            $display("FAIL drop_done: got done0=%b dout0=%h, expected 1 5555aaaa",
                     a_m0_done, a_m0_dout);
        end
    endtask

`ifdef DVC_ARB_LOCK_EN
    // m0 holds lock: four m0 grants, one m1 grant, then m0 again.
    task automatic test_lock();
        logic exp_seq [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        m0_lock = 1'b1;
        m0_req = 1'b1; m0_addr = 32'h100; m0_ctl = 4'h1;
        m1_req = 1'b1; m1_addr = 32'h200; m1_ctl = 4'h2;
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 20; k++) begin
                if (a_dev_ctl != 4'h0) break;
                step();
            end
            n_checks++;
            if (a_dev_ctl == 4'h0 || a_gnt !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL lock_grant[%0d]: got gnt=%b ctl=%h, expected gnt=%b",
                         i, a_gnt, a_dev_ctl, exp_seq[i]);
            end
            step();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_lat4_write();
        test_reset_in_wait();
        test_ctl_zero_and_drop();
`ifdef DVC_ARB_LOCK_EN
        test_lock();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
